// File: rtl/field_extract.sv
// field_extract
//   Read-side bit-field extractor. The source byte is rotated so that the
//   addressed field lands at bit 0, then the result is masked to the field length
//   and optionally sign-extended. It is a two-stage pipeline with a valid/ready
//   handshake on both sides.
//
//   Field addressing matches the merge unit:
//     extract(merge(dst, f, D0, L), D0, L) == f & mask(L)
//
// Parameters
//   SIGN_EXT   1: bits above the field MSB copy the field MSB; 0: zero-filled
//
// Ports
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  src_in/D0/L_select valid this cycle
//   in_ready   out  1  stage 1 can accept this cycle
//   src_in     in   8  source byte
//   D0         in   3  field position code (rotate right by 7-D0)
//   L_select   in   3  field length; 0 = 8 bits, n = n bits
//   out_valid  out  1  field_out holds a result
//   out_ready  in   1  consumer accepts field_out this cycle
//   field_out  out  8  extracted field, right-justified
module field_extract #(
   parameter logic SIGN_EXT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] src_in,
   input  logic [2:0] D0,
   input  logic [2:0] L_select,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] field_out
);

   logic       s1_valid;
   logic       s2_valid;
   logic [7:0] s1_rot;
   logic [2:0] s1_len;

   logic [3:0] rot_amt;
   logic [7:0] rot;
   logic [7:0] mask;
   logic [7:0] result;
   logic       s2_adv;
   logic       accept;

   // Rotate right by 7-D0, which is simply ~D0 in 3 bits. When the amount is 0
   // the left shift by 8 contributes nothing, so no special case is needed.
   always_comb begin
      rot_amt = {1'b0, ~D0};
      rot     = (src_in >> rot_amt) | (src_in << (4'd8 - rot_amt));
   end

   // Handshake: in_ready may depend on out_ready combinationally, but no data
   // path does.
   always_comb begin
      s2_adv   = s1_valid & (~s2_valid | out_ready);
      in_ready = ~s1_valid | s2_adv;
      accept   = in_valid & in_ready;
   end

   // Stage-2 datapath: mask to the field length, then extend the sign if enabled.
   // A length code of 0 means the full byte and never sign-extends.
   always_comb begin
      if (s1_len == 3'd0) begin
         mask = 8'hFF;
      end else begin
         mask = 8'hFF >> (4'd8 - {1'b0, s1_len});
      end
      result = s1_rot & mask;
      if (SIGN_EXT && (s1_len != 3'd0) && s1_rot[s1_len - 3'd1]) begin
         result = result | ~mask;
      end
   end

   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s1_rot    <= '0;
         s1_len    <= '0;
         field_out <= '0;
      end else begin
         if (accept) begin
            s1_rot <= rot;
            s1_len <= L_select;
         end
         s1_valid <= accept | (s1_valid & ~s2_adv);
         if (s2_adv) begin
            field_out <= result;
         end
         s2_valid <= s2_adv | (s2_valid & ~out_ready);
      end
   end

endmodule
